// File: rtl/ido_pkg.sv
// ---------------------------------------------------------------------------
// ido_pkg
// Definitions shared by the IDO 4:2:2 packer and the IDI 4:2:2 -> 4:4:4
// unpacker.
//   - ido_fmt_e      : output/input format codes
//   - C_MID          : chroma fill value used when no chroma of a type exists
//   - LANE_SWAP_*    : meaning of the Y/C byte-lane swap control bit
//   - chroma_e       : chroma component type (Cb / Cr)
//   - native_chroma(): chroma type carried natively by a pixel of given parity
// ---------------------------------------------------------------------------
package ido_pkg;

  typedef enum logic [1:0] {
    FMT_YUV422 = 2'd0,
    FMT_YUV444 = 2'd1,
    FMT_RAW    = 2'd2,
    FMT_RGB565 = 2'd3
  } ido_fmt_e;

  localparam logic [7:0] C_MID = 8'd128;

  // swap = OFF: Y in the low byte, C in the high byte; ON: the reverse.
  localparam logic LANE_SWAP_OFF = 1'b0;
  localparam logic LANE_SWAP_ON  = 1'b1;

  typedef enum logic {
    CHROMA_CB = 1'b0,
    CHROMA_CR = 1'b1
  } chroma_e;

  // Even pixels carry Cb unless the Cb/Cr order bit flips the pairing.
  function automatic chroma_e native_chroma(input logic parity, input logic cbcr_ord);
    return chroma_e'(parity ^ cbcr_ord);
  endfunction

endpackage

// File: rtl/idi_c_recon.sv
// ---------------------------------------------------------------------------
// idi_c_recon
// Single-channel missing-chroma reconstruction (purely combinational).
// Produces the chroma of one type for a pixel that does not carry it.
//   i_prev / i_prev_vld : same-type chroma of pixel n-1 and its validity
//   i_next / i_next_vld : same-type chroma of pixel n+1 and its validity
//   i_hist / i_hist_vld : last same-type chroma seen earlier in the line
//   i_even              : pixel n has parity 0
//   r_c_interp          : 0 = pair replicate, 1 = neighbour average
//   o_c                 : reconstructed chroma
// ---------------------------------------------------------------------------
module idi_c_recon #(
  parameter int              DW    = 8,
  parameter logic [DW-1:0]   C_MID = DW'(ido_pkg::C_MID)
) (
  input  logic [DW-1:0] i_prev,
  input  logic          i_prev_vld,
  input  logic [DW-1:0] i_next,
  input  logic          i_next_vld,
  input  logic [DW-1:0] i_hist,
  input  logic          i_hist_vld,
  input  logic          i_even,
  input  logic          r_c_interp,
  output logic [DW-1:0] o_c
);

  import ido_pkg::*;

  logic [DW:0]   sum;
  logic [DW-1:0] avg;

  // One extra bit keeps the rounded sum exact for full-scale neighbours.
  assign sum = {1'b0, i_prev} + {1'b0, i_next} + {{DW{1'b0}}, 1'b1};
  assign avg = sum[DW:1];

  always_comb begin
    o_c = C_MID;
    if (r_c_interp) begin
      if (i_prev_vld && i_next_vld) begin
        o_c = avg;
      end else if (i_prev_vld) begin
        o_c = i_prev;
      end else if (i_next_vld) begin
        o_c = i_next;
      end
    end else if (i_even) begin
      // Even pixel pairs with the following pixel; at a truncated line end
      // fall back to the most recent chroma of this type in the line.
      if (i_next_vld) begin
        o_c = i_next;
      end else if (i_hist_vld) begin
        o_c = i_hist;
      end
    end else begin
      if (i_prev_vld) begin
        o_c = i_prev;
      end else if (i_hist_vld) begin
        o_c = i_hist;
      end
    end
  end

endmodule

// File: rtl/idi_yuv_422_to_444.sv
// ---------------------------------------------------------------------------
// idi_yuv_422_to_444
// Rebuilds 8-bit Y/Cb/Cr 4:4:4 from a 16-bit YUV 4:2:2 stream carried on the
// IDO sync protocol. Fixed two-cycle latency for syncs and data.
//   pclk, prst_n           : pixel clock, async active-low reset
//   i_vstr/i_vend          : frame start / end
//   i_hstr/i_hend          : line start / end (on first / last dvld)
//   i_dvld, i_data         : data valid, packed {C,Y} or {Y,C} sample
//   r_yuv_swap_yc          : byte-lane select
//   r_cbcr_ord             : 0 = even pixel carries Cb, 1 = even carries Cr
//   r_c_interp             : 0 = pair replicate, 1 = neighbour average
//   o_vstr..o_dvld         : syncs delayed by two cycles
//   o_data_y/cb/cr         : 4:4:4 pixel, updated only on delayed dvld
// Pipeline: S0 = live input (pixel n+1), S1 = pixel n, S2 = chroma of n-1.
// ---------------------------------------------------------------------------
module idi_yuv_422_to_444 #(
  parameter int            DW    = 8,
  parameter logic [DW-1:0] C_MID = DW'(ido_pkg::C_MID)
) (
  input  logic            pclk,
  input  logic            prst_n,
  input  logic            i_vstr,
  input  logic            i_vend,
  input  logic            i_hstr,
  input  logic            i_hend,
  input  logic            i_dvld,
  input  logic [2*DW-1:0] i_data,
  input  logic            r_yuv_swap_yc,
  input  logic            r_cbcr_ord,
  input  logic            r_c_interp,
  output logic            o_vstr,
  output logic            o_vend,
  output logic            o_hstr,
  output logic            o_hend,
  output logic            o_dvld,
  output logic [DW-1:0]   o_data_y,
  output logic [DW-1:0]   o_data_cb,
  output logic [DW-1:0]   o_data_cr
);

  import ido_pkg::*;

  // S0 decode
  logic          s0_first;
  logic          s0_par;
  logic [DW-1:0] s0_y;
  logic [DW-1:0] s0_c;

  // registers
  logic          phase_q, phase_d;
  logic          s1_vstr_q, s1_vstr_d;
  logic          s1_vend_q, s1_vend_d;
  logic          s1_hstr_q, s1_hstr_d;
  logic          s1_hend_q, s1_hend_d;
  logic          s1_dvld_q, s1_dvld_d;
  logic [DW-1:0] s1_y_q, s1_y_d;
  logic [DW-1:0] s1_c_q, s1_c_d;
  logic          s1_par_q, s1_par_d;
  logic [DW-1:0] s2_c_q, s2_c_d;
  logic          s2_vld_q, s2_vld_d;
  logic [DW-1:0] hist_cb_q, hist_cb_d;
  logic          hist_cb_vld_q, hist_cb_vld_d;
  logic [DW-1:0] hist_cr_q, hist_cr_d;
  logic          hist_cr_vld_q, hist_cr_vld_d;
  logic          o_vstr_q, o_vstr_d;
  logic          o_vend_q, o_vend_d;
  logic          o_hstr_q, o_hstr_d;
  logic          o_hend_q, o_hend_d;
  logic          o_dvld_q, o_dvld_d;
  logic [DW-1:0] o_y_q, o_y_d;
  logic [DW-1:0] o_cb_q, o_cb_d;
  logic [DW-1:0] o_cr_q, o_cr_d;

  // S1 evaluation
  logic          s1_first;
  logic          prev_vld;
  logic          next_vld;
  logic          s1_even;
  chroma_e       s1_ctype;
  logic [DW-1:0] rec_cb;
  logic [DW-1:0] rec_cr;

  always_comb begin
    s0_first = i_hstr & i_dvld;
    s0_par   = s0_first ? 1'b0 : phase_q;
    if (r_yuv_swap_yc == LANE_SWAP_ON) begin
      s0_y = i_data[2*DW-1:DW];
      s0_c = i_data[DW-1:0];
    end else begin
      s0_y = i_data[DW-1:0];
      s0_c = i_data[2*DW-1:DW];
    end
  end

  always_comb begin
    s1_first = s1_hstr_q & s1_dvld_q;
    // s2_vld_q guards against dvld arriving before any line has started.
    prev_vld = s1_dvld_q & s2_vld_q & ~s1_first;
    next_vld = i_dvld & ~s1_hend_q;
    s1_even  = ~s1_par_q;
    s1_ctype = native_chroma(s1_par_q, r_cbcr_ord);
  end

  // Neighbours of the opposite parity carry the chroma type pixel n lacks,
  // so both channels see the same prev/next samples; only the missing one
  // is used.
  idi_c_recon #(.DW(DW), .C_MID(C_MID)) u_recon_cb (
    .i_prev     (s2_c_q),
    .i_prev_vld (prev_vld),
    .i_next     (s0_c),
    .i_next_vld (next_vld),
    .i_hist     (hist_cb_q),
    .i_hist_vld (hist_cb_vld_q & ~s1_first),
    .i_even     (s1_even),
    .r_c_interp (r_c_interp),
    .o_c        (rec_cb)
  );

  idi_c_recon #(.DW(DW), .C_MID(C_MID)) u_recon_cr (
    .i_prev     (s2_c_q),
    .i_prev_vld (prev_vld),
    .i_next     (s0_c),
    .i_next_vld (next_vld),
    .i_hist     (hist_cr_q),
    .i_hist_vld (hist_cr_vld_q & ~s1_first),
    .i_even     (s1_even),
    .r_c_interp (r_c_interp),
    .o_c        (rec_cr)
  );

  always_comb begin
    phase_d       = phase_q;
    s1_vstr_d     = i_vstr;
    s1_vend_d     = i_vend;
    s1_hstr_d     = i_hstr;
    s1_hend_d     = i_hend;
    s1_dvld_d     = i_dvld;
    s1_y_d        = s1_y_q;
    s1_c_d        = s1_c_q;
    s1_par_d      = s1_par_q;
    s2_c_d        = s2_c_q;
    s2_vld_d      = s2_vld_q;
    hist_cb_d     = hist_cb_q;
    hist_cb_vld_d = hist_cb_vld_q;
    hist_cr_d     = hist_cr_q;
    hist_cr_vld_d = hist_cr_vld_q;
    o_vstr_d      = s1_vstr_q;
    o_vend_d      = s1_vend_q;
    o_hstr_d      = s1_hstr_q;
    o_hend_d      = s1_hend_q;
    o_dvld_d      = s1_dvld_q;
    o_y_d         = o_y_q;
    o_cb_d        = o_cb_q;
    o_cr_d        = o_cr_q;

    if (i_dvld) begin
      phase_d  = ~s0_par;
      s1_y_d   = s0_y;
      s1_c_d   = s0_c;
      s1_par_d = s0_par;
    end

    if (s1_dvld_q) begin
      s2_c_d   = s1_c_q;
      s2_vld_d = 1'b1;

      // Line start wipes the history before the first pixel is recorded.
      if (s1_first) begin
        hist_cb_vld_d = 1'b0;
        hist_cr_vld_d = 1'b0;
      end
      if (s1_ctype == CHROMA_CB) begin
        hist_cb_d     = s1_c_q;
        hist_cb_vld_d = 1'b1;
      end else begin
        hist_cr_d     = s1_c_q;
        hist_cr_vld_d = 1'b1;
      end

      o_y_d = s1_y_q;
      if (s1_ctype == CHROMA_CB) begin
        o_cb_d = s1_c_q;
        o_cr_d = rec_cr;
      end else begin
        o_cb_d = rec_cb;
        o_cr_d = s1_c_q;
      end
    end
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      phase_q       <= 1'b0;
      s1_vstr_q     <= 1'b0;
      s1_vend_q     <= 1'b0;
      s1_hstr_q     <= 1'b0;
      s1_hend_q     <= 1'b0;
      s1_dvld_q     <= 1'b0;
      s1_y_q        <= '0;
      s1_c_q        <= '0;
      s1_par_q      <= 1'b0;
      s2_c_q        <= '0;
      s2_vld_q      <= 1'b0;
      hist_cb_q     <= '0;
      hist_cb_vld_q <= 1'b0;
      hist_cr_q     <= '0;
      hist_cr_vld_q <= 1'b0;
      o_vstr_q      <= 1'b0;
      o_vend_q      <= 1'b0;
      o_hstr_q      <= 1'b0;
      o_hend_q      <= 1'b0;
      o_dvld_q      <= 1'b0;
      o_y_q         <= '0;
      o_cb_q        <= '0;
      o_cr_q        <= '0;
    end else begin
      phase_q       <= phase_d;
      s1_vstr_q     <= s1_vstr_d;
      s1_vend_q     <= s1_vend_d;
      s1_hstr_q     <= s1_hstr_d;
      s1_hend_q     <= s1_hend_d;
      s1_dvld_q     <= s1_dvld_d;
      s1_y_q        <= s1_y_d;
      s1_c_q        <= s1_c_d;
      s1_par_q      <= s1_par_d;
      s2_c_q        <= s2_c_d;
      s2_vld_q      <= s2_vld_d;
      hist_cb_q     <= hist_cb_d;
      hist_cb_vld_q <= hist_cb_vld_d;
      hist_cr_q     <= hist_cr_d;
      hist_cr_vld_q <= hist_cr_vld_d;
      o_vstr_q      <= o_vstr_d;
      o_vend_q      <= o_vend_d;
      o_hstr_q      <= o_hstr_d;
      o_hend_q      <= o_hend_d;
      o_dvld_q      <= o_dvld_d;
      o_y_q         <= o_y_d;
      o_cb_q        <= o_cb_d;
      o_cr_q        <= o_cr_d;
    end
  end

  assign o_vstr    = o_vstr_q;
  assign o_vend    = o_vend_q;
  assign o_hstr    = o_hstr_q;
  assign o_hend    = o_hend_q;
  assign o_dvld    = o_dvld_q;
  assign o_data_y  = o_y_q;
  assign o_data_cb = o_cb_q;
  assign o_data_cr = o_cr_q;

endmodule

// File: tb/tb_idi_yuv_422_to_444.sv
module tb_idi_yuv_422_to_444;

  localparam int DW = 8;

  logic          pclk;
  logic          prst_n;
  logic          i_vstr, i_vend, i_hstr, i_hend, i_dvld;
  logic [2*DW-1:0] i_data;
  logic          r_yuv_swap_yc, r_cbcr_ord, r_c_interp;
  logic          o_vstr, o_vend, o_hstr, o_hend, o_dvld;
  logic [DW-1:0] o_data_y, o_data_cb, o_data_cr;

  idi_yuv_422_to_444 #(.DW(DW)) dut (
    .pclk          (pclk),
    .prst_n        (prst_n),
    .i_vstr        (i_vstr),
    .i_vend        (i_vend),
    .i_hstr        (i_hstr),
    .i_hend        (i_hend),
    .i_dvld        (i_dvld),
    .i_data        (i_data),
    .r_yuv_swap_yc (r_yuv_swap_yc),
    .r_cbcr_ord    (r_cbcr_ord),
    .r_c_interp    (r_c_interp),
    .o_vstr        (o_vstr),
    .o_vend        (o_vend),
    .o_hstr        (o_hstr),
    .o_hend        (o_hend),
    .o_dvld        (o_dvld),
    .o_data_y      (o_data_y),
    .o_data_cb     (o_data_cb),
    .o_data_cr     (o_data_cr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // directed beat table: one row per input pixel, with its expected output
  int b_hs[32], b_he[32], b_y[32], b_c[32], e_cb[32], e_cr[32];
  int nb = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic push(input int hs, input int he, input int y, input int c,
                      input int cb, input int cr);
    b_hs[nb] = hs; b_he[nb] = he; b_y[nb] = y; b_c[nb] = c;
    e_cb[nb] = cb; e_cr[nb] = cr;
    nb++;
  endtask

  task automatic drive_pix(input int hs, input int he, input int y, input int c);
    logic [7:0] yb, cb8;
    yb  = y[7:0];
    cb8 = c[7:0];
    i_dvld = 1'b1;
    i_hstr = (hs != 0);
    i_hend = (he != 0);
    i_data = r_yuv_swap_yc ? {yb, cb8} : {cb8, yb};
  endtask

  task automatic drive_idle();
    i_dvld = 1'b0;
    i_hstr = 1'b0;
    i_hend = 1'b0;
    i_data = '0;
  endtask

  // Streams the table one pixel per cycle; output of beat p is due 2 cycles
  // after it is driven. One cycle after the last output, dvld must drop and
  // the data must hold the last pixel.
  task automatic run_beats(input string tag);
    for (int k = 0; k < nb + 3; k++) begin
      @(posedge pclk); #1;
      if (k < nb) drive_pix(b_hs[k], b_he[k], b_y[k], b_c[k]);
      else        drive_idle();
      if (k >= 2 && k < nb + 2) begin
        int p;
        p = k - 2;
        chk($sformatf("%s.p%0d.dvld", tag, p), 32'(o_dvld), 1);
        chk($sformatf("%s.p%0d.hstr", tag, p), 32'(o_hstr), 32'(b_hs[p]));
        chk($sformatf("%s.p%0d.hend", tag, p), 32'(o_hend), 32'(b_he[p]));
        chk($sformatf("%s.p%0d.y",    tag, p), 32'(o_data_y),  32'(b_y[p]));
        chk($sformatf("%s.p%0d.cb",   tag, p), 32'(o_data_cb), 32'(e_cb[p]));
        chk($sformatf("%s.p%0d.cr",   tag, p), 32'(o_data_cr), 32'(e_cr[p]));
      end else if (k == nb + 2) begin
        chk($sformatf("%s.idle_dvld", tag), 32'(o_dvld), 0);
        chk($sformatf("%s.hold_y", tag), 32'(o_data_y), 32'(b_y[nb-1]));
      end
    end
    nb = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".vstr"}, 32'(o_vstr), 0);
    chk({tag, ".vend"}, 32'(o_vend), 0);
    chk({tag, ".hstr"}, 32'(o_hstr), 0);
    chk({tag, ".hend"}, 32'(o_hend), 0);
    chk({tag, ".dvld"}, 32'(o_dvld), 0);
    chk({tag, ".y"},    32'(o_data_y), 0);
    chk({tag, ".cb"},   32'(o_data_cb), 0);
    chk({tag, ".cr"},   32'(o_data_cr), 0);
  endtask

  initial begin
    prst_n = 1'b0;
    i_vstr = 1'b0;
    i_vend = 1'b0;
    drive_idle();
    r_yuv_swap_yc = 1'b0;
    r_cbcr_ord    = 1'b0;
    r_c_interp    = 1'b0;

    repeat (3) @(posedge pclk);
    #1;
    chk_all_zero("reset");
    @(negedge pclk);
    prst_n = 1'b1;

    // replicate, 4-pixel line
    push(1, 0, 10, 100, 100, 200);
    push(0, 0, 11, 200, 100, 200);
    push(0, 0, 12, 110, 110, 210);
    push(0, 1, 13, 210, 110, 210);
    run_beats("rep4");

    // average, same line
    r_c_interp = 1'b1;
    push(1, 0, 10, 100, 100, 200);
    push(0, 0, 11, 200, 105, 200);
    push(0, 0, 12, 110, 110, 205);
    push(0, 1, 13, 210, 110, 210);
    run_beats("avg4");

    // average rounding half up
    push(1, 0, 20, 100, 100, 50);
    push(0, 0, 21, 50,  101, 50);
    push(0, 1, 22, 101, 101, 50);
    run_beats("avg_round");

    // average full-scale neighbours need the extra sum bit
    push(1, 0, 30, 255, 255, 9);
    push(0, 0, 31, 9,   255, 9);
    push(0, 1, 32, 254, 254, 9);
    run_beats("avg_full");

    // odd width 3, replicate: last even pixel falls back to line history
    r_c_interp = 1'b0;
    push(1, 0, 10, 100, 100, 200);
    push(0, 0, 11, 200, 100, 200);
    push(0, 1, 12, 110, 110, 200);
    run_beats("rep3");

    // width 1, both modes
    push(1, 1, 10, 100, 100, 128);
    run_beats("rep1");
    r_c_interp = 1'b1;
    push(1, 1, 10, 100, 100, 128);
    run_beats("avg1");

    // lane swap and Cr-first ordering
    r_c_interp    = 1'b0;
    r_yuv_swap_yc = 1'b1;
    r_cbcr_ord    = 1'b1;
    push(1, 1, 8'h0A, 8'h64, 128, 8'h64);
    run_beats("swap1");
    push(1, 0, 8'h40, 8'h11, 8'h22, 8'h11);
    push(0, 1, 8'h41, 8'h22, 8'h22, 8'h11);
    run_beats("swap_ord2");
    r_yuv_swap_yc = 1'b0;
    r_cbcr_ord    = 1'b0;

    // back-to-back lines: no phase or history leakage across hstr
    push(1, 0, 1, 50, 50, 60);
    push(0, 0, 2, 60, 50, 60);
    push(0, 1, 3, 70, 70, 60);
    push(1, 1, 4, 80, 80, 128);
    push(1, 0, 5, 90, 90, 95);
    push(0, 1, 6, 95, 90, 95);
    run_beats("b2b");

    // frame syncs ride the same 2-cycle delay and leave data alone
    @(posedge pclk); #1; i_vstr = 1'b1;
    @(posedge pclk); #1; i_vstr = 1'b0; i_vend = 1'b1;
    chk("vstr_d1", 32'(o_vstr), 0);
    @(posedge pclk); #1; i_vend = 1'b0;
    chk("vstr_d2", 32'(o_vstr), 1);
    chk("vend_d1", 32'(o_vend), 0);
    @(posedge pclk); #1;
    chk("vstr_d3", 32'(o_vstr), 0);
    chk("vend_d2", 32'(o_vend), 1);
    chk("vsync_hold_y",  32'(o_data_y), 6);
    chk("vsync_hold_cr", 32'(o_data_cr), 95);

    // asynchronous reset in the middle of a line
    for (int k = 0; k < 3; k++) begin
      @(posedge pclk); #1;
      drive_pix((k == 0) ? 1 : 0, 0, 10 + k, (k == 1) ? 200 : ((k == 0) ? 100 : 110));
    end
    chk("pre_rst_y", 32'(o_data_y), 10);
    chk("pre_rst_dvld", 32'(o_dvld), 1);
    #2 prst_n = 1'b0;
    #1;
    chk_all_zero("rst_async");
    drive_idle();
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    prst_n = 1'b1;

    push(1, 0, 10, 100, 100, 200);
    push(0, 0, 11, 200, 100, 200);
    push(0, 0, 12, 110, 110, 210);
    push(0, 1, 13, 210, 110, 210);
    run_beats("post_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
